// File: rtl/gps_ca_acquire_if.sv
// Chip-stream and status bundle between the sampling front end, the C/A
// acquisition engine and the downstream tracking logic.
interface gps_ca_acquire_if #(
  parameter int CW = 9
);
  logic [5:0]    sv_num;
  logic          start;
  logic          chip_in;
  logic          chip_valid;
  logic          busy;
  logic          locked;
  logic          done;
  logic          fail;
  logic          lost;
  logic          err;
  logic [9:0]    code_phase;
  logic [CW-1:0] corr_peak;

  modport master (
    output sv_num, start, chip_in, chip_valid,
    input  busy, locked, done, fail, lost, err, code_phase, corr_peak
  );

  modport slave (
    input  sv_num, start, chip_in, chip_valid,
    output busy, locked, done, fail, lost, err, code_phase, corr_peak
  );
endinterface

// File: rtl/gps_ca_acquire.sv
// Serial C/A code acquisition: regenerates the PRN locally and slips it one
// chip per failed dwell until the received stream correlates, then monitors lock.
module gps_ca_acquire #(
  parameter int CORR_LEN = 256,
  parameter int THRESH   = 230
) (
  input  logic             sys_clk_50,
  input  logic             sync_rst_n,
  gps_ca_acquire_if.slave  bus
);
  localparam int CW = $clog2(CORR_LEN + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

  typedef struct packed {
    logic [10:1] g1;
    logic [10:1] g2;
    logic [9:0]  idx;
  } gen_t;

  localparam gen_t GEN_INIT = {10'h3FF, 10'h3FF, 10'd0};

  // One chip of G1/G2 advance; both registers reload together at the end of the code period.
  function automatic gen_t gen_step(input gen_t s);
    gen_t n;
    if (s.idx == 10'd1022) begin
      n = GEN_INIT;
    end else begin
      n.g1  = {s.g1[9:1], s.g1[3] ^ s.g1[10]};
      n.g2  = {s.g2[9:1], s.g2[2] ^ s.g2[3] ^ s.g2[6] ^ s.g2[8] ^ s.g2[9] ^ s.g2[10]};
      n.idx = s.idx + 10'd1;
    end
    return n;
  endfunction

  function automatic logic [10:1] taps(input logic [3:0] a, input logic [3:0] b);
    return (10'd1 << (a - 4'd1)) | (10'd1 << (b - 4'd1));
  endfunction

  function automatic logic [10:1] prn_mask(input logic [5:0] prn);
    logic [10:1] m;
    m = '0;
    case (prn)
      6'd1:  m = taps(4'd2, 4'd6);
      6'd2:  m = taps(4'd3, 4'd7);
      6'd3:  m = taps(4'd4, 4'd8);
      6'd4:  m = taps(4'd5, 4'd9);
      6'd5:  m = taps(4'd1, 4'd9);
      6'd6:  m = taps(4'd2, 4'd10);
      6'd7:  m = taps(4'd1, 4'd8);
      6'd8:  m = taps(4'd2, 4'd9);
      6'd9:  m = taps(4'd3, 4'd10);
      6'd10: m = taps(4'd2, 4'd3);
      6'd11: m = taps(4'd3, 4'd4);
      6'd12: m = taps(4'd5, 4'd6);
      6'd13: m = taps(4'd6, 4'd7);
      6'd14: m = taps(4'd7, 4'd8);
      6'd15: m = taps(4'd8, 4'd9);
      6'd16: m = taps(4'd9, 4'd10);
      6'd17: m = taps(4'd1, 4'd4);
      6'd18: m = taps(4'd2, 4'd5);
      6'd19: m = taps(4'd3, 4'd6);
      6'd20: m = taps(4'd4, 4'd7);
      6'd21: m = taps(4'd5, 4'd8);
      6'd22: m = taps(4'd6, 4'd9);
      6'd23: m = taps(4'd1, 4'd3);
      6'd24: m = taps(4'd4, 4'd6);
      6'd25: m = taps(4'd5, 4'd7);
      6'd26: m = taps(4'd6, 4'd8);
      6'd27: m = taps(4'd7, 4'd9);
      6'd28: m = taps(4'd8, 4'd10);
      6'd29: m = taps(4'd1, 4'd6);
      6'd30: m = taps(4'd2, 4'd7);
      6'd31: m = taps(4'd3, 4'd8);
      6'd32: m = taps(4'd4, 4'd9);
      default: m = '0;
    endcase
    return m;
  endfunction

  state_t        state;
  gen_t          gen;
  logic [10:1]   mask;
  logic [5:0]    sv_prev;
  logic          start_prev;
  logic [CW-1:0] chip_cnt;
  logic [CW-1:0] agree;
  logic [9:0]    slip;
  logic          busy_r, locked_r, done_r, fail_r, lost_r, err_r;
  logic [9:0]    code_phase_r;
  logic [CW-1:0] corr_peak_r;

  logic          local_chip;
  logic          sv_changed;
  logic          start_edge;
  logic          sv_ok;
  logic [CW-1:0] agree_next;
  logic          dwell_end;
  logic          dwell_pass;
  gen_t          gen_one;
  gen_t          gen_two;

  // The two G2 taps are distinct bits, so the parity of the masked register is G2[a]^G2[b].
  assign local_chip = gen.g1[10] ^ (^(gen.g2 & mask));
  assign sv_changed = (bus.sv_num != sv_prev);
  assign start_edge = bus.start & ~start_prev;
  assign sv_ok      = (bus.sv_num >= 6'd1) && (bus.sv_num <= 6'd32);
  assign agree_next = agree + CW'(bus.chip_in == local_chip);
  assign dwell_end  = (chip_cnt == CW'(CORR_LEN - 1));
  assign dwell_pass = (agree_next >= CW'(THRESH));
  assign gen_one    = gen_step(gen);
  assign gen_two    = gen_step(gen_one);

  always_ff @(posedge sys_clk_50) begin
    if (!sync_rst_n) begin
      state        <= IDLE;
      gen          <= GEN_INIT;
      mask         <= '0;
      sv_prev      <= '0;
      start_prev   <= 1'b0;
      chip_cnt     <= '0;
      agree        <= '0;
      slip         <= '0;
      busy_r       <= 1'b0;
      locked_r     <= 1'b0;
      done_r       <= 1'b0;
      fail_r       <= 1'b0;
      lost_r       <= 1'b0;
      err_r        <= 1'b0;
      code_phase_r <= '0;
      corr_peak_r  <= '0;
    end else begin
      sv_prev    <= bus.sv_num;
      start_prev <= bus.start;
      done_r     <= 1'b0;
      lost_r     <= 1'b0;
      err_r      <= 1'b0;

      // A PRN change silently abandons any search or lock and masks a coincident start.
      if (sv_changed) begin
        state    <= IDLE;
        busy_r   <= 1'b0;
        locked_r <= 1'b0;
      end else if (start_edge) begin
        if (sv_ok) begin
          state    <= SEARCH;
          busy_r   <= 1'b1;
          locked_r <= 1'b0;
          fail_r   <= 1'b0;
          gen      <= GEN_INIT;
          mask     <= prn_mask(bus.sv_num);
          chip_cnt <= '0;
          agree    <= '0;
          slip     <= '0;
        end else begin
          state    <= IDLE;
          busy_r   <= 1'b0;
          locked_r <= 1'b0;
          err_r    <= 1'b1;
        end
      end else if (state != IDLE && bus.chip_valid) begin
        if (!dwell_end) begin
          chip_cnt <= chip_cnt + CW'(1);
          agree    <= agree_next;
          gen      <= gen_one;
        end else begin
          chip_cnt    <= '0;
          agree       <= '0;
          corr_peak_r <= agree_next;
          if (state == SEARCH) begin
            if (dwell_pass) begin
              state        <= LOCKED;
              busy_r       <= 1'b0;
              locked_r     <= 1'b1;
              done_r       <= 1'b1;
              code_phase_r <= slip;
              gen          <= gen_one;
            end else if (slip == 10'd1022) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              fail_r <= 1'b1;
              gen    <= gen_one;
            end else begin
              // Skipping one extra local chip shifts the next dwell one phase later.
              slip <= slip + 10'd1;
              gen  <= gen_two;
            end
          end else begin
            gen <= gen_one;
            if (!dwell_pass) begin
              state    <= IDLE;
              locked_r <= 1'b0;
              lost_r   <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.busy       = busy_r;
  assign bus.locked     = locked_r;
  assign bus.done       = done_r;
  assign bus.fail       = fail_r;
  assign bus.lost       = lost_r;
  assign bus.err        = err_r;
  assign bus.code_phase = code_phase_r;
  assign bus.corr_peak  = corr_peak_r;
endmodule

// File: tb/tb_gps_ca_acquire.sv
// Randomised bench for gps_ca_acquire against a correlation model that scores
// each dwell directly from PRN code tables and the slip count.
module tb_gps_ca_acquire;
  localparam int L    = 32;
  localparam int TH   = 29;
  localparam int CW   = $clog2(L + 1);
  localparam int MAXS = 33000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gps_ca_acquire_if #(.CW(CW)) bus();

  gps_ca_acquire #(.CORR_LEN(L), .THRESH(TH)) dut (
    .sys_clk_50 (clk),
    .sync_rst_n (rst_n),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit code [1:32][0:1022];
  bit stream_bits [0:MAXS-1];
  int feed_pos;
  int tap_a [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int tap_b [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full-period code tables built straight from the two generator polynomials.
  task automatic buildCodes();
    int r1 [1:10];
    int r2 [1:10];
    int f1, f2;
    for (int p = 1; p <= 32; p++) begin
      for (int k = 1; k <= 10; k++) begin
        r1[k] = 1;
        r2[k] = 1;
      end
      for (int n = 0; n < 1023; n++) begin
        code[p][n] = bit'(r1[10] ^ r2[tap_a[p]] ^ r2[tap_b[p]]);
        f1 = r1[3] ^ r1[10];
        f2 = r2[2] ^ r2[3] ^ r2[6] ^ r2[8] ^ r2[9] ^ r2[10];
        for (int k = 10; k >= 2; k--) begin
          r1[k] = r1[k-1];
          r2[k] = r2[k-1];
        end
        r1[1] = f1;
        r2[1] = f2;
      end
    end
  endtask

  task automatic buildStream(input int tx, input int offset, input int noise_mod);
    bit flip;
    for (int n = 0; n < MAXS; n++) begin
      flip = (noise_mod > 0) && ($urandom_range(noise_mod - 1, 0) == 0);
      stream_bits[n] = code[tx][(offset + n) % 1023] ^ flip;
    end
  endtask

  // Dwell d sees stream chip n against local chip n + s, s being slips made so far.
  function automatic int dwellAgree(input int sv, input int s, input int d);
    int a = 0;
    int n;
    for (int c = 0; c < L; c++) begin
      n = d * L + c;
      if (stream_bits[n] == code[sv][(n + s) % 1023]) a++;
    end
    return a;
  endfunction

  function automatic void predict(input int sv, output bit lock, output int dwell, output int peak);
    int a = 0;
    lock  = 1'b0;
    dwell = 1022;
    for (int j = 0; j < 1023; j++) begin
      a = dwellAgree(sv, j, j);
      if (a >= TH) begin
        lock  = 1'b1;
        dwell = j;
        break;
      end
    end
    peak = a;
  endfunction

  task automatic startAcq(input int sv);
    bus.chip_valid = 1'b0;
    bus.start      = 1'b0;
    bus.sv_num     = sv[5:0];
    tick();
    bus.start      = 1'b1;
    bus.chip_valid = 1'b1;
    bus.chip_in    = bit'($urandom);
    tick();
    bus.start      = 1'b0;
    bus.chip_valid = 1'b0;
    feed_pos       = 0;
  endtask

  // Feeds stream chips until done/lost, the chip limit, or the cycle budget.
  task automatic applyStimulus(input int gap_mode, input int max_chips, input int max_cycles, output bit hit);
    bit v;
    hit = 1'b0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      if (feed_pos >= max_chips) break;
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 4 == 0);
        default: v = bit'($urandom_range(1, 0));
      endcase
      bus.chip_valid = v;
      bus.chip_in    = v ? stream_bits[feed_pos] : bit'($urandom);
      tick();
      if (v) feed_pos++;
      if (bus.done || bus.lost) begin
        hit = 1'b1;
        break;
      end
    end
    bus.chip_valid = 1'b0;
  endtask

  task automatic runSearch(input int sv, input int gap_mode, input string tag);
    bit exp_lock;
    int exp_dwell, exp_peak, exp_chips, budget;
    bit hit;
    predict(sv, exp_lock, exp_dwell, exp_peak);
    exp_chips = (exp_dwell + 1) * L;
    budget = (gap_mode == 0) ? exp_chips + 20 : (gap_mode == 1) ? 4 * exp_chips + 20 : 8 * exp_chips + 200;
    startAcq(sv);
    checkOutput({tag, "_busy_start"}, 32'(bus.busy), 1);
    applyStimulus(gap_mode, exp_chips + L, budget, hit);
    checkOutput({tag, "_done"}, 32'(hit && bus.done), 1);
    checkOutput({tag, "_chips"}, feed_pos, exp_chips);
    checkOutput({tag, "_locked"}, 32'(bus.locked), 32'(exp_lock));
    checkOutput({tag, "_fail"}, 32'(bus.fail), 32'(!exp_lock));
    checkOutput({tag, "_busy_end"}, 32'(bus.busy), 0);
    checkOutput({tag, "_peak"}, 32'(bus.corr_peak), exp_peak);
    if (exp_lock) checkOutput({tag, "_phase"}, 32'(bus.code_phase), exp_dwell);
    tick();
    checkOutput({tag, "_done_pulse"}, 32'(bus.done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] acc;
    logic [9:0]  first10;
    bit hit;
    int tx, off;

    bus.sv_num = '0;
    bus.start = 1'b0;
    bus.chip_in = 1'b0;
    bus.chip_valid = 1'b0;
    buildCodes();
    for (int i = 0; i < 10; i++) first10[9-i] = code[1][i];
    checkOutput("prn1_first10", 32'(first10), 32'h320);

    repeat (3) tick();
    checkOutput("in_reset_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    acc = '0;
    repeat (20) begin
      tick();
      acc = acc | 32'({bus.busy, bus.locked, bus.done, bus.fail, bus.lost, bus.err,
                        bus.code_phase, bus.corr_peak});
    end
    checkOutput("reset_idle_outputs", acc, 0);

    $display("[TB] PRN1 offset 0, continuous chips");
    buildStream(1, 0, 0);
    runSearch(1, 0, "off0");
    applyStimulus(0, 3 * L, 1000, hit);
    checkOutput("mon_no_event", 32'(hit), 0);
    checkOutput("mon_locked", 32'(bus.locked), 1);
    checkOutput("mon_peak", 32'(bus.corr_peak), dwellAgree(1, 0, 2));
    for (int n = 3 * L; n < 4 * L; n++) stream_bits[n] = ~stream_bits[n];
    applyStimulus(0, 4 * L, 1000, hit);
    checkOutput("lost_pulse", 32'(hit && bus.lost), 1);
    checkOutput("lost_peak", 32'(bus.corr_peak), dwellAgree(1, 0, 3));
    checkOutput("lost_locked", 32'(bus.locked), 0);
    checkOutput("lost_busy", 32'(bus.busy), 0);
    tick();
    checkOutput("lost_pulse_end", 32'(bus.lost), 0);

    $display("[TB] PRN1 offset 100, one valid chip in four");
    buildStream(1, 100, 0);
    runSearch(1, 1, "off100");

    $display("[TB] PRN5 stream searched as PRN1");
    buildStream(5, 0, 0);
    runSearch(1, 0, "wrongprn");

    $display("[TB] PRN change mid-search, then invalid PRN start");
    buildStream(2, 0, 0);
    startAcq(1);
    applyStimulus(0, 20, 100, hit);
    checkOutput("abort_pre_busy", 32'(bus.busy), 1);
    bus.sv_num = 6'd2;
    tick();
    checkOutput("abort_busy", 32'(bus.busy), 0);
    acc = '0;
    repeat (5) begin
      acc = acc | 32'({bus.done, bus.lost, bus.busy});
      tick();
    end
    checkOutput("abort_quiet", acc, 0);
    bus.sv_num = 6'd0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput("err_pulse", 32'(bus.err), 1);
    checkOutput("err_busy", 32'(bus.busy), 0);
    tick();
    checkOutput("err_pulse_end", 32'(bus.err), 0);
    checkOutput("err_busy_after", 32'(bus.busy), 0);

    $display("[TB] randomised acquisitions");
    for (int t = 0; t < 4; t++) begin
      tx  = $urandom_range(32, 1);
      off = $urandom_range(40, 0);
      $display("[TB] trial %0d: prn %0d offset %0d", t, tx, off);
      buildStream(tx, off, 100);
      runSearch(tx, 2, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
